// File: rtl/array_serializer.sv
// array_serializer: buffers whole 4-element result arrays from the upstream
// array-result stage and streams them out one element per cycle over a
// valid/ready interface, element 0 first. The upstream stage cannot be
// stalled, so arrays arriving with no free slot are dropped and flagged
// through a sticky overflow bit.
module array_serializer #(
    parameter int DEPTH  = 2,
    parameter int DATA_W = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [DATA_W-1:0]       array_in [0:3],
    input  logic                    array_valid,
    output logic [DATA_W-1:0]       out_data,
    output logic [1:0]              out_index,
    output logic                    out_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [$clog2(DEPTH):0]  occupancy,
    output logic                    overflow,
    input  logic                    ovf_clr
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam logic [OCC_W-1:0] FULL = OCC_W'(DEPTH);

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    state_t state;
    state_t state_next;

    logic [DATA_W-1:0] mem [0:DEPTH-1][0:3];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [1:0]        idx;
    logic [OCC_W-1:0]  occ_next;

    logic handshake;
    logic pop;
    logic wr_accept;
    logic drop;

    // A slot being released by the final-element handshake can be refilled
    // in the same cycle, so a full buffer still accepts on that cycle.
    assign handshake = out_valid && out_ready;
    assign pop       = handshake && (idx == 2'd3);
    assign wr_accept = array_valid && ((occupancy < FULL) || pop);
    assign drop      = array_valid && !wr_accept;

    // Occupancy after this cycle's write and pop; a simultaneous pair cancels.
    always_comb begin
        occ_next = occupancy;
        if (wr_accept && !pop) begin
            occ_next = occupancy + OCC_W'(1);
        end else if (!wr_accept && pop) begin
            occ_next = occupancy - OCC_W'(1);
        end
    end

    // Array storage; contents need no reset since occupancy guards every read.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            for (int k = 0; k < 4; k++) begin
                mem[wr_ptr][k] <= array_in[k];
            end
        end
    end

    // Pointers, element index, occupancy and the sticky overflow flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            idx       <= '0;
            occupancy <= '0;
            overflow  <= 1'b0;
        end else begin
            occupancy <= occ_next;
            if (wr_accept) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (handshake) begin
                idx <= idx + 2'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (drop) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state: start streaming after a write, stop once the buffer drains.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (wr_accept) begin
                    state_next = STREAM;
                end
            end
            STREAM: begin
                if (pop && (occ_next == '0)) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Outputs present the head slot element while streaming, zero otherwise.
    always_comb begin
        out_valid = 1'b0;
        out_data  = '0;
        out_index = 2'd0;
        out_last  = 1'b0;
        if (state == STREAM) begin
            out_valid = 1'b1;
            out_data  = mem[rd_ptr][idx];
            out_index = idx;
            out_last  = (idx == 2'd3);
        end
    end

endmodule
